stopwatch_mode_controller: RTL and testbench

Sequences the four-digit MM:SS stopwatch datapath. Decodes debounced button pulses into operating modes (stopped, running, digit-set, expired) and drives the `set` input of the digit-setting block. Generates the 1 Hz count-enable strobe and the direction for the BCD digit counters, and detects the count limits from the current BCD time value.

---
 rtl/stopwatch_mode_controller.sv | 154 +++++++++++++++
 tb/tb_stopwatch_mode_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mode_controller.sv
// rtl/stopwatch_mode_controller.sv - mode sequencing, 1 Hz strobe and limit detection for an MM:SS stopwatch
module stopwatch_mode_controller #(
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int TICK_FREQUENCY_IN_HZ        = 1,
   parameter int NUMBER_OF_DIGITS            = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_stop,
   input  logic                          set_mode,
   input  logic                          clear,
   input  logic                          count_down,
   input  logic [4*NUMBER_OF_DIGITS-1:0] time_value,
   output logic                          set,
   output logic                          count_enable,
   output logic                          up_down,
   output logic                          clear_counters,
   output logic                          running,
   output logic                          done
);

   localparam int DIVIDE          = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
   localparam int PRESCALER_WIDTH = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam int TIME_WIDTH      = 4 * NUMBER_OF_DIGITS;
   localparam logic [PRESCALER_WIDTH-1:0] TERMINAL = PRESCALER_WIDTH'(DIVIDE - 1);

   // Upper count limit: digits alternate 9 (units) and 5 (tens), e.g. 59:59.
   function automatic logic [TIME_WIDTH-1:0] max_time();
      logic [TIME_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
         v[4*i +: 4] = ((i % 2) == 0) ? 4'h9 : 4'h5;
      end
      return v;
   endfunction

   localparam logic [TIME_WIDTH-1:0] MAX_TIME = max_time();

   typedef enum logic [1:0] {
      S_STOPPED = 2'd0,
      S_RUN     = 2'd1,
      S_SET     = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t                     state;
   state_t                     next_state;
   logic [PRESCALER_WIDTH-1:0] prescaler;
   logic [PRESCALER_WIDTH-1:0] next_prescaler;
   logic                       next_up_down;
   logic                       next_clear;
   logic                       at_zero_q;
   logic                       at_max_q;
   logic                       terminal;
   logic                       at_limit;
   logic                       do_clear;
   logic                       do_set;
   logic                       do_start;

   // Only the highest-priority pulse of a cycle takes effect.
   assign do_clear = clear;
   assign do_set   = !clear && set_mode;
   assign do_start = !clear && !set_mode && start_stop;

   // Limits come from registered flags so the strobe never sees time_value combinationally;
   // time_value is stable for at least one cycle before every terminal count.
   assign terminal     = (prescaler == TERMINAL);
   assign at_limit     = up_down ? at_max_q : at_zero_q;
   assign count_enable = (state == S_RUN) && terminal && !at_limit;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_STOPPED;
      end else begin
         state <= next_state;
      end
   end

   // Next-state, prescaler, direction latch and clear request.
   always_comb begin
      next_state     = state;
      next_prescaler = '0;
      next_up_down   = up_down;
      next_clear     = 1'b0;
      case (state)
         S_STOPPED: begin
            if (do_clear) begin
               next_clear = 1'b1;
            end else if (do_set) begin
               next_state = S_SET;
            end else if (do_start && !(count_down && (time_value == '0))) begin
               next_state   = S_RUN;
               next_up_down = !count_down;
            end
         end
         S_RUN: begin
            if (do_clear) begin
               next_clear = 1'b1;
            end else if (do_start) begin
               next_state = S_STOPPED;
            end else if (terminal && at_limit) begin
               next_state = S_EXPIRED;
            end else begin
               next_prescaler = terminal ? '0 : prescaler + PRESCALER_WIDTH'(1);
            end
         end
         S_SET: begin
            if (do_clear) begin
               next_clear = 1'b1;
            end else if (do_set) begin
               next_state = S_STOPPED;
            end
         end
         S_EXPIRED: begin
            if (do_clear) begin
               next_clear = 1'b1;
               next_state = S_STOPPED;
            end else if (do_set) begin
               next_state = S_SET;
            end else if (do_start) begin
               next_state = S_STOPPED;
            end
         end
         default: begin
            next_state = S_STOPPED;
         end
      endcase
   end

   // Registered outputs, prescaler and limit flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler      <= '0;
         up_down        <= 1'b1;
         clear_counters <= 1'b0;
         set            <= 1'b0;
         running        <= 1'b0;
         done           <= 1'b0;
         at_zero_q      <= 1'b0;
         at_max_q       <= 1'b0;
      end else begin
         prescaler      <= next_prescaler;
         up_down        <= next_up_down;
         clear_counters <= next_clear;
         set            <= (next_state == S_SET);
         running        <= (next_state == S_RUN);
         done           <= (next_state == S_EXPIRED);
         at_zero_q      <= (time_value == '0);
         at_max_q       <= (time_value == MAX_TIME);
      end
   end

endmodule

// File: tb/tb_stopwatch_mode_controller.sv
// tb/tb_stopwatch_mode_controller.sv - self-checking bench for stopwatch_mode_controller
module tb_stopwatch_mode_controller;

   localparam int DIVIDE = 10;

   localparam int M_STOPPED = 0;
   localparam int M_RUN     = 1;
   localparam int M_SET     = 2;
   localparam int M_EXPIRED = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_stop;
   logic        set_mode;
   logic        clear;
   logic        count_down;
   logic [15:0] time_value;
   logic        set;
   logic        count_enable;
   logic        up_down;
   logic        clear_counters;
   logic        running;
   logic        done;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   stopwatch_mode_controller #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(DIVIDE),
      .TICK_FREQUENCY_IN_HZ(1),
      .NUMBER_OF_DIGITS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_stop(start_stop),
      .set_mode(set_mode),
      .clear(clear),
      .count_down(count_down),
      .time_value(time_value),
      .set(set),
      .count_enable(count_enable),
      .up_down(up_down),
      .clear_counters(clear_counters),
      .running(running),
      .done(done)
   );

   function automatic int to_sec(input logic [15:0] v);
      return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] from_sec(input int s);
      logic [15:0] v;
      int m;
      int q;
      m = s / 60;
      q = s % 60;
      v = {4'(m / 10), 4'(m % 10), 4'(q / 10), 4'(q % 10)};
      return v;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic c, input logic sm, input logic ss);
      clear      = c;
      set_mode   = sm;
      start_stop = ss;
      next_cycle();
      clear      = 1'b0;
      set_mode   = 1'b0;
      start_stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_stop = 1'b0; set_mode = 1'b0; clear = 1'b0; count_down = 1'b0;
      time_value = 16'h0000;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      next_cycle();
      vectors++;
      if ({set, count_enable, up_down, clear_counters, running, done} !== 6'b001000) begin
         miscompares++;
         $display("FAIL reset_outputs got=%b want=001000",
                  {set, count_enable, up_down, clear_counters, running, done});
      end
   endtask

   task automatic test_count_up();
      count_down = 1'b0;
      time_value = 16'h0000;
      pulse(1'b0, 1'b0, 1'b1);
      vectors++;
      if (running !== 1'b1 || up_down !== 1'b1) begin
         miscompares++;
         $display("FAIL count_up_entry running=%b up_down=%b want 1 1", running, up_down);
      end
      for (int c = 0; c < 30; c++) begin
         vectors++;
         if (count_enable !== ((c % DIVIDE) == DIVIDE - 1)) begin
            miscompares++;
            $display("FAIL count_up_strobe cycle=%0d got=%b want=%b", c, count_enable,
                     (c % DIVIDE) == DIVIDE - 1);
         end
         next_cycle();
      end
      pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_count_down_expire();
      count_down = 1'b1;
      time_value = 16'h0001;
      pulse(1'b0, 1'b0, 1'b1);
      vectors++;
      if (running !== 1'b1 || up_down !== 1'b0) begin
         miscompares++;
         $display("FAIL down_entry running=%b up_down=%b want 1 0", running, up_down);
      end
      for (int c = 0; c < DIVIDE - 1; c++) next_cycle();
      vectors++;
      if (count_enable !== 1'b1) begin
         miscompares++;
         $display("FAIL down_first_strobe got=%b want=1", count_enable);
      end
      next_cycle();
      time_value = 16'h0000;
      for (int c = 0; c < DIVIDE - 1; c++) next_cycle();
      vectors++;
      if (count_enable !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL down_limit_strobe ce=%b done=%b want 0 0", count_enable, done);
      end
      next_cycle();
      vectors++;
      if (done !== 1'b1 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL down_expired done=%b running=%b want 1 0", done, running);
      end
      pulse(1'b0, 1'b0, 1'b1);
      vectors++;
      if (done !== 1'b0 || running !== 1'b0 || set !== 1'b0) begin
         miscompares++;
         $display("FAIL down_stop done=%b running=%b set=%b want 0 0 0", done, running, set);
      end
   endtask

   task automatic test_count_up_expire();
      count_down = 1'b0;
      time_value = 16'h5959;
      next_cycle();
      pulse(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < DIVIDE - 1; c++) next_cycle();
      vectors++;
      if (count_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL up_limit_strobe got=%b want=0", count_enable);
      end
      next_cycle();
      vectors++;
      if (done !== 1'b1 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL up_expired done=%b running=%b want 1 0", done, running);
      end
      pulse(1'b0, 1'b0, 1'b1);
      time_value = 16'h0000;
   endtask

   task automatic test_simultaneous();
      pulse(1'b1, 1'b1, 1'b1);
      vectors++;
      if (clear_counters !== 1'b1 || set !== 1'b0 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_pulse clr=%b set=%b running=%b want 1 0 0",
                  clear_counters, set, running);
      end
      next_cycle();
      vectors++;
      if (clear_counters !== 1'b0 || set !== 1'b0 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_after clr=%b set=%b running=%b want 0 0 0",
                  clear_counters, set, running);
      end
   endtask

   task automatic test_set_mode();
      pulse(1'b0, 1'b1, 1'b0);
      vectors++;
      if (set !== 1'b1) begin
         miscompares++;
         $display("FAIL set_enter got=%b want=1", set);
      end
      pulse(1'b0, 1'b0, 1'b1);
      vectors++;
      if (set !== 1'b1 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL set_ignore_start set=%b running=%b want 1 0", set, running);
      end
      pulse(1'b0, 1'b1, 1'b0);
      vectors++;
      if (set !== 1'b0 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL set_leave set=%b running=%b want 0 0", set, running);
      end
   endtask

   task automatic test_count_down_zero();
      count_down = 1'b1;
      time_value = 16'h0000;
      pulse(1'b0, 1'b0, 1'b1);
      next_cycle();
      vectors++;
      if (running !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL down_zero_start running=%b done=%b want 0 0", running, done);
      end
      count_down = 1'b0;
   endtask

   task automatic test_async_reset();
      count_down = 1'b1;
      time_value = 16'h0030;
      pulse(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) next_cycle();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({set, count_enable, up_down, clear_counters, running, done} !== 6'b001000) begin
         miscompares++;
         $display("FAIL async_reset got=%b want=001000",
                  {set, count_enable, up_down, clear_counters, running, done});
      end
      next_cycle();
      rst = 1'b0;
      count_down = 1'b0;
      time_value = 16'h0000;
      next_cycle();
      pulse(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < DIVIDE + 1; c++) begin
         vectors++;
         if (count_enable !== (c == DIVIDE - 1)) begin
            miscompares++;
            $display("FAIL restart_strobe cycle=%0d got=%b want=%b", c, count_enable,
                     c == DIVIDE - 1);
         end
         next_cycle();
      end
      pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      int          mode;
      int          phase;
      logic        dir_up;
      logic        clr;
      logic        exp_ce;
      logic        lim;
      logic        nxt_clr;
      logic [15:0] nxt_tv;
      logic [15:0] picks [5];
      rst = 1'b1;
      start_stop = 1'b0; set_mode = 1'b0; clear = 1'b0; count_down = 1'b0;
      time_value = 16'h0000;
      next_cycle();
      rst = 1'b0;
      mode = M_STOPPED; phase = 0; dir_up = 1'b1; clr = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         lim    = dir_up ? (time_value == 16'h5959) : (time_value == 16'h0000);
         exp_ce = (mode == M_RUN) && (phase == DIVIDE - 1) && !lim;
         vectors++;
         if ({set, running, done, up_down, clear_counters, count_enable} !==
             {mode == M_SET, mode == M_RUN, mode == M_EXPIRED, dir_up, clr, exp_ce}) begin
            miscompares++;
            $display("FAIL random n=%0d got=%b want=%b", n,
                     {set, running, done, up_down, clear_counters, count_enable},
                     {mode == M_SET, mode == M_RUN, mode == M_EXPIRED, dir_up, clr, exp_ce});
         end
         clear      = ($urandom % 20) == 0;
         set_mode   = ($urandom % 12) == 0;
         start_stop = ($urandom % 6) == 0;
         if (($urandom % 15) == 0) count_down = ~count_down;
         nxt_clr = 1'b0;
         if (clear) begin
            nxt_clr = 1'b1;
            if (mode == M_RUN) phase = 0;
            if (mode == M_EXPIRED) mode = M_STOPPED;
         end else if (set_mode && mode != M_RUN) begin
            mode = (mode == M_SET) ? M_STOPPED : M_SET;
         end else if (start_stop && !set_mode && mode == M_STOPPED) begin
            if (!(count_down && time_value == 16'h0000)) begin
               mode = M_RUN; phase = 0; dir_up = !count_down;
            end
         end else if (start_stop && !set_mode && mode == M_RUN) begin
            mode = M_STOPPED;
         end else if (start_stop && !set_mode && mode == M_EXPIRED) begin
            mode = M_STOPPED;
         end else if (mode == M_RUN) begin
            if (phase == DIVIDE - 1 && lim) mode = M_EXPIRED;
            else phase = (phase + 1) % DIVIDE;
         end
         nxt_tv = time_value;
         if (clr) nxt_tv = 16'h0000;
         else if (exp_ce) nxt_tv = from_sec(dir_up ? to_sec(time_value) + 1 : to_sec(time_value) - 1);
         clr = nxt_clr;
         next_cycle();
         time_value = nxt_tv;
         if (mode == M_SET && ($urandom % 3) == 0) begin
            picks[0] = 16'h0000; picks[1] = 16'h0001; picks[2] = 16'h5958; picks[3] = 16'h5959;
            picks[4] = from_sec(int'($urandom_range(0, 3599)));
            time_value = picks[$urandom_range(0, 4)];
         end
      end
      clear = 1'b0; set_mode = 1'b0; start_stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down_expire();
      test_count_up_expire();
      test_simultaneous();
      test_set_mode();
      test_count_down_zero();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
